// File: rtl/ir_frame_decoder.sv
// rtl/ir_frame_decoder.sv - pulse-width IR frame decoder on the 1 MHz clkus domain
module ir_frame_decoder #(
  parameter int BITS      = 17,
  parameter int NBITS     = 8,
  parameter int MARK_MIN  = 5000,
  parameter int ONE_MIN   = 20000,
  parameter int START_MIN = 30000,
  parameter int GAP_MAX   = 50000
) (
  input  logic             clkus,
  input  logic             rst,
  input  logic             in,
  output logic [NBITS-1:0] data,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [BITS-1:0] MARK_L  = BITS'(MARK_MIN);
  localparam logic [BITS-1:0] ONE_L   = BITS'(ONE_MIN);
  localparam logic [BITS-1:0] START_L = BITS'(START_MIN);
  localparam logic [BITS-1:0] GAP_L   = BITS'(GAP_MAX);
  localparam logic [CW-1:0]   LAST    = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, START, GAP, BIT} state_t;

  state_t           state, state_n;
  logic             prev;
  logic [BITS-1:0]  cnt;
  logic [NBITS-1:0] shift, shift_n, data_n;
  logic [CW-1:0]    bitcnt, bitcnt_n;
  logic             valid_n, err_n;
  logic             lvl_edge, fall, rise;

  assign lvl_edge = in ^ prev;
  assign fall     = lvl_edge & ~in;
  assign rise     = lvl_edge & in;
  assign busy     = (state != IDLE);

  // On an edge cycle cnt still holds the length of the level that just ended.
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    bitcnt_n = bitcnt;
    data_n   = data;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: if (fall) state_n = START;
      START: begin
        if (rise) begin
          if (cnt >= START_L) begin
            state_n  = GAP;
            shift_n  = '0;
            bitcnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (fall) begin
          state_n = BIT;
        end else if (in && cnt >= GAP_L) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      BIT: begin
        if (rise) begin
          if (cnt < MARK_L) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else if (cnt >= START_L) begin
            // an overlong mark is taken as a fresh start pulse
            state_n  = GAP;
            shift_n  = '0;
            bitcnt_n = '0;
            err_n    = 1'b1;
          end else begin
            shift_n[bitcnt] = (cnt >= ONE_L);
            if (bitcnt == LAST) begin
              data_n  = shift_n;
              valid_n = 1'b1;
              state_n = IDLE;
            end else begin
              bitcnt_n = bitcnt + CW'(1);
              state_n  = GAP;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prev   <= 1'b1;
      cnt    <= '0;
      shift  <= '0;
      bitcnt <= '0;
      data   <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      prev   <= in;
      if (lvl_edge)
        cnt <= BITS'(1);
      else if (cnt != '1)
        cnt <= cnt + BITS'(1);
      shift  <= shift_n;
      bitcnt <= bitcnt_n;
      data   <= data_n;
      valid  <= valid_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// tb/tb_ir_frame_decoder.sv - scoreboard bench for ir_frame_decoder with timings scaled by 1/100
module tb_ir_frame_decoder;

  localparam int MARK  = 50;
  localparam int ONE   = 200;
  localparam int STRT  = 300;
  localparam int GAPM  = 500;
  localparam int T_ST  = 350;
  localparam int T_ONE = 250;
  localparam int T_ZER = 100;
  localparam int T_GAP = 100;

  logic       clkus = 1'b0;
  logic       rst   = 1'b1;
  logic       ir_in = 1'b1;
  logic [7:0] data;
  logic       valid, err, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;

  ir_frame_decoder #(
    .BITS(10), .NBITS(8), .MARK_MIN(MARK), .ONE_MIN(ONE),
    .START_MIN(STRT), .GAP_MAX(GAPM)
  ) dut (
    .clkus(clkus), .rst(rst), .in(ir_in),
    .data(data), .valid(valid), .err(err), .busy(busy)
  );

  always #5 clkus = ~clkus;

  always @(posedge clkus) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every valid/err pulse must match the oldest expectation
  always @(negedge clkus) begin
    if (valid || err) begin
      check("valid_err_exclusive", {31'd0, valid & err}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b required none (cycle %0d)", valid, err, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_err", {31'd0, err}, {31'd0, e.is_err});
        check("pulse_cycle", cyc, e.cyc);
        if (!e.is_err) check("frame_data", {24'd0, data}, {24'd0, e.d});
      end
    end
  end

  task automatic hold(input logic v, input int n);
    ir_in = v;
    repeat (n) @(negedge clkus);
  endtask

  task automatic bit_pulse(input int low_len);
    hold(1'b1, T_GAP);
    hold(1'b0, low_len);
  endtask

  // called at the negedge where the line is about to rise
  task automatic expect_valid(input logic [7:0] d);
    exp_q.push_back('{is_err: 1'b0, d: d, cyc: cyc + 1});
  endtask

  task automatic expect_err(input int delay);
    exp_q.push_back('{is_err: 1'b1, d: 8'h00, cyc: cyc + delay});
  endtask

  task automatic frame(input logic [7:0] b);
    hold(1'b0, T_ST);
    for (int i = 0; i < 8; i++) bit_pulse(b[i] ? T_ONE : T_ZER);
    expect_valid(b);
    hold(1'b1, 200);
  endtask

  int lens[8];

  initial begin
    @(negedge clkus);
    @(negedge clkus);
    rst = 1'b0;
    hold(1'b1, 1000);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, valid}, 32'd0);
    check("idle_err", {31'd0, err}, 32'd0);
    check("idle_data", {24'd0, data}, 32'd0);

    frame(8'hA5);
    check("a5_data_held", {24'd0, data}, 32'hA5);

    // third gap too long
    hold(1'b0, T_ST);
    bit_pulse(T_ONE);
    bit_pulse(T_ZER);
    expect_err(GAPM + 1);
    hold(1'b1, 600);
    check("abort_data_kept", {24'd0, data}, 32'hA5);
    check("abort_busy", {31'd0, busy}, 32'd0);

    // short start is silent noise
    hold(1'b0, 120);
    hold(1'b1, 5);
    check("short_start_busy", {31'd0, busy}, 32'd0);
    frame(8'h3C);

    // width boundaries: 200->1, 199->0, 50->0, 299->1
    lens = '{200, 199, 200, 200, 199, 50, 299, 200};
    hold(1'b0, T_ST);
    for (int i = 0; i < 8; i++) bit_pulse(lens[i]);
    expect_valid(8'hCD);
    hold(1'b1, 200);

    // mark below minimum
    hold(1'b0, T_ST);
    bit_pulse(MARK - 1);
    expect_err(1);
    hold(1'b1, 200);
    check("short_mark_busy", {31'd0, busy}, 32'd0);
    check("short_mark_data", {24'd0, data}, 32'hCD);

    // start-length mark mid-frame resynchronises
    hold(1'b0, T_ST);
    bit_pulse(T_ONE);
    bit_pulse(STRT);
    expect_err(1);
    for (int i = 0; i < 8; i++) bit_pulse(lens[i] == 0 ? 0 : ((8'h96 >> i) & 1) != 0 ? T_ONE : T_ZER);
    expect_valid(8'h96);
    hold(1'b1, 200);

    // saturated stuck-low still counts as a start
    hold(1'b0, 2000);
    for (int i = 0; i < 8; i++) bit_pulse(i == 0 ? T_ONE : T_ZER);
    expect_valid(8'h01);
    hold(1'b1, 200);

    // reset during bit 4
    hold(1'b0, T_ST);
    for (int i = 0; i < 4; i++) bit_pulse(T_ONE);
    hold(1'b1, T_GAP);
    hold(1'b0, 50);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clkus);
    ir_in = 1'b1;
    rst   = 1'b0;
    hold(1'b1, 100);
    frame(8'h5A);

    hold(1'b1, 50);
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_frame_decoder.md
Name: ir_frame_decoder

Overview:
- Decodes the clean, deglitched infrared level stream from the IR deoscillation stage into 8-bit data frames.
- Sits directly downstream of that stage on the same 1 MHz `clkus` domain; its `in` is the deoscillator's registered `out`, so no synchroniser is needed.
- Protocol is pulse-width coded and sized for the deoscillator's 5 ms minimum pulse:
  - line idles high (1);
  - one long low start pulse, then NBITS low data pulses, LSB first;
  - a short low pulse is 0, a long low pulse is 1;
  - high gaps separate the pulses.
- Result is presented as a byte plus a one-cycle valid strobe to the command logic.

Parameters:
- BITS, 17: width of the level-duration counter; saturates at 2^BITS-1.
- NBITS, 8: data bits per frame; `data` width.
- MARK_MIN, 5000: minimum legal low pulse, in cycles (µs).
- ONE_MIN, 20000: low pulse of at least this length and below START_MIN decodes as 1; below it decodes as 0.
- START_MIN, 30000: low pulse of at least this length is a start pulse.
- GAP_MAX, 50000: maximum high gap inside a frame; exceeding it aborts the frame.

Ports:
- clkus  input  1  1 MHz clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  deglitched IR level; idle = 1.
- data  output  NBITS  last complete frame, LSB = first received bit.
- valid  output  1  one-cycle pulse: `data` just updated.
- err  output  1  one-cycle pulse: frame aborted.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, `rst`=1) clears everything:
  - state=IDLE, prev=1, cnt=0, shift=0, bitcnt=0;
  - data=0, valid=0, err=0.
- Edge detection:
  - `prev` registers `in` every cycle.
  - Edge = (`in` != `prev`).
- Level counter:
  - On an edge cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
  - On an edge cycle, L = cnt is the length in cycles of the level just ended; all classification uses L.
- State machine (all transitions on rising `clkus`):
  - IDLE: on falling edge (in=0, prev=1) -> START.
  - START (measuring low):
    - On rising edge with L >= START_MIN -> GAP, with bitcnt=0, shift=0.
    - On rising edge with L < START_MIN -> IDLE silently; no `err`, since that is noise/idle.
  - GAP (measuring high):
    - On falling edge -> BIT.
    - If cnt reaches GAP_MAX while `in`=1 -> IDLE, pulse err.
  - BIT (measuring low). On rising edge:
    - L < MARK_MIN -> IDLE, pulse err.
    - MARK_MIN <= L < ONE_MIN -> bit 0.
    - ONE_MIN <= L < START_MIN -> bit 1.
    - L >= START_MIN -> resynchronise: treat as a new start -> GAP, bitcnt=0, shift=0, pulse err.
    - A decoded bit is shifted into shift[bitcnt] and bitcnt increments.
    - If this was bit NBITS-1, in the same cycle: data <= completed word, valid pulses, state -> IDLE.
    - Otherwise -> GAP.
- Output timing:
  - `valid` and `err` are registered and high for exactly one cycle.
  - They are asserted the cycle after the edge that caused them.
  - `valid` and `err` are never high together.
  - `data` holds its value until the next valid frame; aborted frames never touch `data`.
- Saturation: cnt saturating during a stuck-low line keeps L >= START_MIN (classifies as start); no wrap-around.
- `busy` is combinational from state (state != IDLE).
- Reset mid-frame: immediate return to IDLE; partial bits are discarded; no valid or err pulse is emitted.

Test Plan:
- Reset then idle high for 100000 cycles -> busy=0, valid=0, err=0, data=0.
- Start low 35000, then bits LSB-first 1,0,1,0,0,1,0,1:
  - bit 1 = low 25000, bit 0 = low 10000, gaps high 10000 each;
  - required: one valid pulse one cycle after the final rising edge, data=8'hA5, err never set.
- Frame as above, but the third gap is held high 60000 -> err pulses exactly once, when cnt hits 50000; data remains at its prior value; busy=0 afterwards.
- Low pulse of 12000 from idle (short start) -> returns to IDLE, no err, no valid; a correct frame sent immediately afterwards decodes normally.
- Boundary widths:
  - low 19999 decodes 0, low 20000 decodes 1;
  - low 4999 in BIT gives err;
  - a 30000 low in BIT gives err plus resync, and the following 8 bits decode as a fresh frame with valid.
- Assert `rst` during bit 4 of a frame -> all outputs 0 within the same cycle; no valid/err; the next full frame decodes correctly.
